spi_adc_scanner: RTL and testbench
==================================

// Module: spi_adc_scanner
// PURPOSE
//  Upstream sequencer for the SPIMaster byte engine. Round-robins the enabled channels of an
//  SPI ADC (MCP3008-style framing). Per channel: issues one SPI frame, captures the response
//  into a per-channel result file, and pulses a sample strobe. Sits between the SPIMaster
//  instance and the bot's sensor/register block.
// PARAMETERS
//  NUM_CH      8    number of ADC channels scanned (1..8)
//  CMD_BITS    5    command frame width, equals SPIMaster TO_SPI_BITS
//  RESP_BITS   10   response width, equals SPIMaster FROM_SPI_BITS
//  XFER_LEN    15   total SPI bits per frame, driven on spi_total_len
//  GAP_CYCLES  50   idle clk cycles after each frame (>= one SPI bit time, lets CS deassert)
//  TIMEOUT     4096 clk cycles allowed from spi_stb_wr to spi_stb_rdy
//  Derived: CH_W=$clog2(NUM_CH) (min 1); LEN_W=$clog2(CMD_BITS+RESP_BITS)
// PORTS
//  clk            in   1          system clock
//  reset_n        in   1          asynchronous reset, active low
//  enable         in   1          scan enable
//  ch_mask        in   NUM_CH     1 = channel included in scan
//  clr_err        in   1          clears timeout_err
//  spi_stb_wr     out  1          1-cycle frame start strobe to SPIMaster
//  spi_stb_rdy    in   1          1-cycle frame complete strobe from SPIMaster
//  spi_to_data    out  CMD_BITS   command {1'b1 start, 1'b1 single-ended, ch[2:0]}, MSB first
//  spi_from_data  in   RESP_BITS  response shift register from SPIMaster
//  spi_total_len  out  LEN_W      constant XFER_LEN
//  rd_addr        in   CH_W       result file read address
//  rd_data        out  RESP_BITS  registered result[rd_addr]
//  rd_valid       out  1          registered valid[rd_addr]
//  sample_stb     out  1          1-cycle pulse: new result stored
//  sample_ch      out  CH_W       channel of that result, valid with sample_stb
//  sample_data    out  RESP_BITS  result, valid with sample_stb
//  scan_done      out  1          1-cycle pulse with sample_stb on the last enabled channel
//  timeout_err    out  1          sticky: a frame timed out
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM=IDLE; cur_ch=NUM_CH-1; result/valid files cleared.
//  FSM states:
//   IDLE  : enable && |ch_mask -> SELECT.
//   SELECT: each cycle cur_ch <= (cur_ch+1) mod NUM_CH (wraps for non-power-of-2 NUM_CH).
//           -> ISSUE when ch_mask[new cur_ch]=1. Leaves within NUM_CH cycles.
//           -> IDLE if !enable or ch_mask==0.
//   ISSUE : spi_stb_wr=1 for exactly one cycle; spi_to_data holds the command from this
//           cycle until the next ISSUE; wait counter cleared; -> WAIT.
//   WAIT  : counter++ each cycle.
//           spi_stb_rdy -> STORE, capturing spi_from_data that cycle.
//           counter==TIMEOUT-1 without rdy -> timeout_err<=1, no store, -> GAP.
//   STORE : result[cur_ch]<=captured; valid[cur_ch]<=1; sample_stb/ch/data presented;
//           scan_done=1 if cur_ch is the highest set bit of ch_mask; -> GAP.
//   GAP   : GAP_CYCLES cycles, then -> SELECT if enable && |ch_mask, else -> IDLE.
//  spi_stb_wr is never asserted outside ISSUE, so at most one frame is outstanding.
//  enable dropping mid-frame: frame completes and is stored; exit via GAP to IDLE (no abort).
//  ch_mask change mid-frame: current channel still stored; new mask used from next SELECT.
//  spi_stb_rdy outside WAIT is ignored.
//  Scan restarts from the channel after the last one served (cur_ch not reset by enable).
//  Read port: 1-cycle latency. Same-cycle write and read of one address returns the old
//   value; the new value appears the following cycle.
//  timeout_err: set in WAIT on timeout, cleared by clr_err; simultaneous set and clear -> set.
//  sample_data is zero-extended/truncated to RESP_BITS. No arithmetic on results.
// TESTING
//  1. ch_mask=8'h05, enable=1, SPI model returns 10'h155 (ch0), 10'h2AA (ch2) ->
//     ISSUE cmd 5'b11000 then 5'b11010; sample_stb for ch0 then ch2; scan_done with ch2;
//     rd_addr=2 -> rd_data=10'h2AA, rd_valid=1.
//  2. Model never returns rdy, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles; no
//     sample_stb; scan continues. clr_err and a new timeout in the same cycle -> stays 1.
//  3. enable drops 3 cycles after spi_stb_wr -> frame still stored; exactly one
//     sample_stb; FSM in IDLE after GAP; no further spi_stb_wr.
//  4. NUM_CH=5, ch_mask=5'h10 -> repeated frames on ch4 only; cur_ch wraps 4->0..3->4;
//     every sample_stb accompanied by scan_done.
//  5. Assert reset_n low during WAIT -> all outputs 0 immediately; results/valid cleared;
//     after release with enable=1 the first frame targets ch0.
//  6. Gap check: consecutive spi_stb_wr pulses are >= GAP_CYCLES+2 cycles after each
//     spi_stb_rdy, and back-to-back frames are never issued.

Source files
------------

// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: round-robin sequencer for an MCP3008-style SPI ADC.
// Issues one SPIMaster frame per enabled channel. Each response goes into a
// per-channel result file, and a sample strobe is pulsed. A quiet gap follows
// every frame so that chip-select can deassert. A frame that is never
// acknowledged raises a sticky timeout flag and the scan moves on.
module spi_adc_scanner #(
    parameter int NUM_CH     = 8,
    parameter int CMD_BITS   = 5,
    parameter int RESP_BITS  = 10,
    parameter int XFER_LEN   = 15,
    parameter int GAP_CYCLES = 50,
    parameter int TIMEOUT    = 4096,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LEN_W     = $clog2(CMD_BITS + RESP_BITS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 clr_err,
    output logic                 spi_stb_wr,
    input  logic                 spi_stb_rdy,
    output logic [CMD_BITS-1:0]  spi_to_data,
    input  logic [RESP_BITS-1:0] spi_from_data,
    output logic [LEN_W-1:0]     spi_total_len,
    input  logic [CH_W-1:0]      rd_addr,
    output logic [RESP_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 sample_stb,
    output logic [CH_W-1:0]      sample_ch,
    output logic [RESP_BITS-1:0] sample_data,
    output logic                 scan_done,
    output logic                 timeout_err
);

    // One counter serves both the response wait and the post-frame gap.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_VAL  = LEN_W'(XFER_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stb_wr_q, stb_wr_d;
    logic [CMD_BITS-1:0]  cmd_q, cmd_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 sample_stb_q, sample_stb_d;
    logic [CH_W-1:0]      sample_ch_q, sample_ch_d;
    logic [RESP_BITS-1:0] sample_data_q, sample_data_d;
    logic                 scan_done_q, scan_done_d;
    logic                 timeout_q, timeout_d;
    logic [RESP_BITS-1:0] result_q [NUM_CH];
    logic [NUM_CH-1:0]    valid_q;
    logic [RESP_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [CH_W-1:0]      nxt_ch_s;
    logic                 mask_any_s;
    logic [CH_W-1:0]      hi_ch_s;
    logic                 rdy_hit_s;
    logic                 timeout_hit_s;

    // Highest enabled channel: the one whose sample closes a scan.
    function automatic logic [CH_W-1:0] highest_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] hi;
        hi = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                hi = CH_W'(i);
            end
        end
        return hi;
    endfunction

    // MCP3008 framing: start bit, single-ended bit, then the 3-bit channel.
    function automatic logic [CMD_BITS-1:0] build_cmd(input logic [CH_W-1:0] ch);
        logic [4:0] c5;
        c5 = {1'b1, 1'b1, 3'(ch)};
        return CMD_BITS'(c5);
    endfunction

    assign nxt_ch_s      = (cur_ch_q == LAST_CH) ? {CH_W{1'b0}} : cur_ch_q + CH_W'(1);
    assign mask_any_s    = |ch_mask;
    assign hi_ch_s       = highest_ch(ch_mask);
    assign rdy_hit_s     = (state_q == ST_WAIT) && spi_stb_rdy;
    assign timeout_hit_s = (state_q == ST_WAIT) && !spi_stb_rdy && (cnt_q == TO_LAST);

    // Next-state logic for the scan sequencer, including the channel pointer and the shared counter.
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && mask_any_s) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (!enable || !mask_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_ch_d = nxt_ch_s;
                    if (ch_mask[nxt_ch_s]) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_stb_rdy) begin
                    state_d = ST_STORE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STORE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (enable && mask_any_s) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; sample fields are loaded as the response is accepted.
    always_comb begin
        stb_wr_d      = (state_d == ST_ISSUE);
        cmd_d         = cmd_q;
        len_d         = LEN_VAL;
        sample_stb_d  = rdy_hit_s;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;
        scan_done_d   = 1'b0;
        timeout_d     = timeout_q;
        if ((state_q == ST_SELECT) && (state_d == ST_ISSUE)) begin
            cmd_d = build_cmd(nxt_ch_s);
        end else begin
            cmd_d = cmd_q;
        end
        if (rdy_hit_s) begin
            sample_ch_d   = cur_ch_q;
            sample_data_d = spi_from_data;
            scan_done_d   = (cur_ch_q == hi_ch_s);
        end else begin
            scan_done_d   = 1'b0;
        end
        if (timeout_hit_s) begin
            timeout_d = 1'b1;
        end else if (clr_err) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Registered read port: reads return the stored value one cycle after the address.
    always_comb begin
        rd_data_d  = {RESP_BITS{1'b0}};
        rd_valid_d = 1'b0;
        if (rd_addr <= LAST_CH) begin
            rd_data_d  = result_q[rd_addr];
            rd_valid_d = valid_q[rd_addr];
        end else begin
            rd_data_d  = {RESP_BITS{1'b0}};
            rd_valid_d = 1'b0;
        end
    end

    // State, channel pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cur_ch_q      <= LAST_CH;
            cnt_q         <= {CNT_W{1'b0}};
            stb_wr_q      <= 1'b0;
            cmd_q         <= {CMD_BITS{1'b0}};
            len_q         <= {LEN_W{1'b0}};
            sample_stb_q  <= 1'b0;
            sample_ch_q   <= {CH_W{1'b0}};
            sample_data_q <= {RESP_BITS{1'b0}};
            scan_done_q   <= 1'b0;
            timeout_q     <= 1'b0;
            rd_data_q     <= {RESP_BITS{1'b0}};
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_ch_q      <= cur_ch_d;
            cnt_q         <= cnt_d;
            stb_wr_q      <= stb_wr_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            sample_stb_q  <= sample_stb_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
            scan_done_q   <= scan_done_d;
            timeout_q     <= timeout_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Result and valid files, written in STORE from the captured response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= {RESP_BITS{1'b0}};
            end
            valid_q <= {NUM_CH{1'b0}};
        end else if (state_q == ST_STORE) begin
            result_q[cur_ch_q] <= sample_data_q;
            valid_q[cur_ch_q]  <= 1'b1;
        end
    end

    assign spi_stb_wr    = stb_wr_q;
    assign spi_to_data   = cmd_q;
    assign spi_total_len = len_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign sample_stb    = sample_stb_q;
    assign sample_ch     = sample_ch_q;
    assign sample_data   = sample_data_q;
    assign scan_done     = scan_done_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner.
// Instance u_dut8: 8 channels, short gap and timeout.
// Instance u_dut5: 5 channels, used for the wrap case.
module tb_spi_adc_scanner;

    localparam int GAP8 = 8;
    localparam int TO8  = 16;
    localparam int GAP5 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // dut8 signals
    logic       rst8_n, en8, clr8, wr8, rdy8, rdv8, sstb8, done8, terr8;
    logic [7:0] mask8;
    logic [4:0] to8;
    logic [9:0] from8, rdd8, sdat8;
    logic [3:0] len8;
    logic [2:0] rda8, sch8;
    logic       resp_en8;

    // dut5 signals
    logic       rst5_n, en5, clr5, wr5, rdy5, rdv5, sstb5, done5, terr5;
    logic [4:0] mask5;
    logic [4:0] to5;
    logic [9:0] from5, rdd5, sdat5;
    logic [3:0] len5;
    logic [2:0] rda5, sch5;

    spi_adc_scanner #(.NUM_CH(8), .GAP_CYCLES(GAP8), .TIMEOUT(TO8)) u_dut8 (
        .clk(clk), .reset_n(rst8_n), .enable(en8), .ch_mask(mask8), .clr_err(clr8),
        .spi_stb_wr(wr8), .spi_stb_rdy(rdy8), .spi_to_data(to8), .spi_from_data(from8),
        .spi_total_len(len8), .rd_addr(rda8), .rd_data(rdd8), .rd_valid(rdv8),
        .sample_stb(sstb8), .sample_ch(sch8), .sample_data(sdat8), .scan_done(done8),
        .timeout_err(terr8)
    );

    spi_adc_scanner #(.NUM_CH(5), .GAP_CYCLES(GAP5), .TIMEOUT(TO8)) u_dut5 (
        .clk(clk), .reset_n(rst5_n), .enable(en5), .ch_mask(mask5), .clr_err(clr5),
        .spi_stb_wr(wr5), .spi_stb_rdy(rdy5), .spi_to_data(to5), .spi_from_data(from5),
        .spi_total_len(len5), .rd_addr(rda5), .rd_data(rdd5), .rd_valid(rdv5),
        .sample_stb(sstb5), .sample_ch(sch5), .sample_data(sdat5), .scan_done(done5),
        .timeout_err(terr5)
    );

    // ADC response per channel
    function automatic logic [9:0] resp_of(input logic [2:0] ch);
        case (ch)
            3'd0:    return 10'h155;
            3'd2:    return 10'h2AA;
            default: return {1'b0, ch, 6'h21};
        endcase
    endfunction

    // SPIMaster models: rdy pulse 5 cycles after the frame strobe
    logic [3:0] m_cnt8, m_cnt5;
    logic [2:0] m_ch8, m_ch5;
    always @(posedge clk or negedge rst8_n) begin
        if (!rst8_n) begin
            m_cnt8 <= 4'd0; rdy8 <= 1'b0; from8 <= 10'd0; m_ch8 <= 3'd0;
        end else begin
            rdy8 <= 1'b0;
            if (wr8 && resp_en8) begin
                m_cnt8 <= 4'd5; m_ch8 <= to8[2:0];
            end else if (m_cnt8 != 4'd0) begin
                m_cnt8 <= m_cnt8 - 4'd1;
                if (m_cnt8 == 4'd1) begin
                    rdy8 <= 1'b1; from8 <= resp_of(m_ch8);
                end
            end
        end
    end
    always @(posedge clk or negedge rst5_n) begin
        if (!rst5_n) begin
            m_cnt5 <= 4'd0; rdy5 <= 1'b0; from5 <= 10'd0; m_ch5 <= 3'd0;
        end else begin
            rdy5 <= 1'b0;
            if (wr5) begin
                m_cnt5 <= 4'd5; m_ch5 <= to5[2:0];
            end else if (m_cnt5 != 4'd0) begin
                m_cnt5 <= m_cnt5 - 4'd1;
                if (m_cnt5 == 4'd1) begin
                    rdy5 <= 1'b1; from5 <= resp_of(m_ch5);
                end
            end
        end
    end

    // Monitor: logs strobes on the falling edge
    int         n_wr8 = 0, n_s8 = 0, b2b8 = 0, stray_done8 = 0, last_rdy8 = 0;
    bit         have_rdy8 = 1'b0, prev_wr8 = 1'b0;
    logic [4:0] cmd_log8[$];
    logic [2:0] sch_log8[$];
    logic [9:0] sdat_log8[$];
    logic       sdone_log8[$];
    int         gap_log8[$];
    int         wr_t5[$];
    logic [4:0] cmd_log5[$];
    logic [2:0] sch_log5[$];
    logic [9:0] sdat_log5[$];
    logic       sdone_log5[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr8) begin
            n_wr8 = n_wr8 + 1;
            cmd_log8.push_back(to8);
            if (have_rdy8) gap_log8.push_back(cyc - last_rdy8);
            if (prev_wr8) b2b8 = b2b8 + 1;
        end
        prev_wr8 = wr8;
        if (rdy8) begin
            last_rdy8 = cyc; have_rdy8 = 1'b1;
        end
        if (sstb8) begin
            n_s8 = n_s8 + 1;
            sch_log8.push_back(sch8); sdat_log8.push_back(sdat8); sdone_log8.push_back(done8);
        end
        if (done8 && !sstb8) stray_done8 = stray_done8 + 1;
        if (wr5) begin
            wr_t5.push_back(cyc); cmd_log5.push_back(to5);
        end
        if (sstb5) begin
            sch_log5.push_back(sch5); sdat_log5.push_back(sdat5); sdone_log5.push_back(done5);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst5_n = 1'b0;
        en8 = 1'b0; mask8 = 8'h00; clr8 = 1'b0; rda8 = 3'd0; resp_en8 = 1'b1;
        en5 = 1'b0; mask5 = 5'h00; clr5 = 1'b0; rda5 = 3'd0;
        tick(2);
        checks++; if (wr8 !== 1'b0) begin errors++; $display("FAIL rst_wr got %b exp 0", wr8); end
        checks++; if (to8 !== 5'd0) begin errors++; $display("FAIL rst_cmd got %h exp 0", to8); end
        checks++; if (len8 !== 4'd0) begin errors++; $display("FAIL rst_len got %0d exp 0", len8); end
        checks++; if ({rdv8, sstb8, done8, terr8} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {rdv8, sstb8, done8, terr8}); end
        rst8_n = 1'b1; rst5_n = 1'b1;
        tick(2);
        checks++; if (len8 !== 4'd15) begin errors++; $display("FAIL len got %0d exp 15", len8); end
        checks++; if (rdv8 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rdv8); end
    endtask

    task automatic test_scan();
        int t = 0;
        int bs = n_s8;
        int bc = cmd_log8.size();
        mask8 = 8'h05; en8 = 1'b1;
        while (n_s8 < bs + 2 && t < 400) begin tick(1); t++; end
        en8 = 1'b0;
        checks++;
        if (n_s8 < bs + 2) begin errors++; $display("FAIL scan_wait got %0d samples exp 2", n_s8 - bs); end
        else begin
            checks++; if (cmd_log8[bc] !== 5'b11000) begin errors++; $display("FAIL scan_cmd0 got %b exp 11000", cmd_log8[bc]); end
            checks++; if (cmd_log8[bc+1] !== 5'b11010) begin errors++; $display("FAIL scan_cmd1 got %b exp 11010", cmd_log8[bc+1]); end
            checks++; if ({sch_log8[bs], sdat_log8[bs], sdone_log8[bs]} !== {3'd0, 10'h155, 1'b0}) begin errors++; $display("FAIL scan_s0 got ch %0d data %h done %b exp ch 0 data 155 done 0", sch_log8[bs], sdat_log8[bs], sdone_log8[bs]); end
            checks++; if ({sch_log8[bs+1], sdat_log8[bs+1], sdone_log8[bs+1]} !== {3'd2, 10'h2AA, 1'b1}) begin errors++; $display("FAIL scan_s1 got ch %0d data %h done %b exp ch 2 data 2aa done 1", sch_log8[bs+1], sdat_log8[bs+1], sdone_log8[bs+1]); end
        end
        tick(30);
        rda8 = 3'd2; tick(2);
        checks++; if ({rdv8, rdd8} !== {1'b1, 10'h2AA}) begin errors++; $display("FAIL rd2 got v %b d %h exp v 1 d 2aa", rdv8, rdd8); end
        rda8 = 3'd1; tick(2);
        checks++; if (rdv8 !== 1'b0) begin errors++; $display("FAIL rd1_valid got %b exp 0", rdv8); end
        rda8 = 3'd0; tick(2);
        checks++; if ({rdv8, rdd8} !== {1'b1, 10'h155}) begin errors++; $display("FAIL rd0 got v %b d %h exp v 1 d 155", rdv8, rdd8); end
    endtask

    task automatic test_timeout();
        int t = 0;
        int k = 0;
        int bs = n_s8;
        resp_en8 = 1'b0; mask8 = 8'h02; en8 = 1'b1;
        while (!wr8 && t < 40) begin tick(1); t++; end
        checks++; if (to8 !== 5'b11001) begin errors++; $display("FAIL to_cmd got %b exp 11001", to8); end
        while (!terr8 && k < 40) begin tick(1); k++; end
        checks++; if (k != 17) begin errors++; $display("FAIL to_latency got %0d exp 17", k); end
        clr8 = 1'b1; tick(1); clr8 = 1'b0;
        checks++; if (terr8 !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", terr8); end
        t = 0;
        while (!wr8 && t < 60) begin tick(1); t++; end
        checks++; if (wr8 !== 1'b1) begin errors++; $display("FAIL to_continue got %b exp 1", wr8); end
        tick(16);
        checks++; if (terr8 !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", terr8); end
        clr8 = 1'b1; tick(1); clr8 = 1'b0;
        checks++; if (terr8 !== 1'b1) begin errors++; $display("FAIL to_set_wins got %b exp 1", terr8); end
        en8 = 1'b0;
        tick(30);
        checks++; if (n_s8 != bs) begin errors++; $display("FAIL to_nosample got %0d exp 0", n_s8 - bs); end
        resp_en8 = 1'b1;
    endtask

    task automatic test_enable_drop();
        int t = 0;
        int bs = n_s8;
        int bw = n_wr8;
        mask8 = 8'h08; en8 = 1'b1;
        while (!wr8 && t < 40) begin tick(1); t++; end
        tick(3);
        en8 = 1'b0;
        tick(60);
        checks++; if (n_wr8 - bw != 1) begin errors++; $display("FAIL drop_frames got %0d exp 1", n_wr8 - bw); end
        checks++;
        if (n_s8 - bs != 1) begin errors++; $display("FAIL drop_samples got %0d exp 1", n_s8 - bs); end
        else begin
            checks++; if ({sch_log8[bs], sdat_log8[bs], sdone_log8[bs]} !== {3'd3, resp_of(3'd3), 1'b1}) begin errors++; $display("FAIL drop_sample got ch %0d data %h done %b exp ch 3 data %h done 1", sch_log8[bs], sdat_log8[bs], sdone_log8[bs], resp_of(3'd3)); end
        end
    endtask

    task automatic test_gap_b2b();
        int t = 0;
        int bs = n_s8;
        int bg = gap_log8.size();
        logic [2:0] ech;
        mask8 = 8'hFF; en8 = 1'b1;
        while (n_s8 < bs + 10 && t < 400) begin tick(1); t++; end
        en8 = 1'b0;
        tick(40);
        checks++;
        if (n_s8 - bs != 10) begin errors++; $display("FAIL gap_samples got %0d exp 10", n_s8 - bs); end
        else begin
            for (int i = 0; i < 10; i++) begin
                ech = 3'(4 + i);
                checks++; if ({sch_log8[bs+i], sdat_log8[bs+i], sdone_log8[bs+i]} !== {ech, resp_of(ech), (ech == 3'd7)}) begin errors++; $display("FAIL gap_seq%0d got ch %0d data %h done %b exp ch %0d", i, sch_log8[bs+i], sdat_log8[bs+i], sdone_log8[bs+i], ech); end
            end
        end
        for (int i = bg; i < gap_log8.size(); i++) begin
            checks++; if (gap_log8[i] < GAP8 + 2) begin errors++; $display("FAIL gap_len got %0d exp >= %0d", gap_log8[i], GAP8 + 2); end
        end
        checks++; if (b2b8 != 0) begin errors++; $display("FAIL b2b got %0d exp 0", b2b8); end
        checks++; if (stray_done8 != 0) begin errors++; $display("FAIL stray_done got %0d exp 0", stray_done8); end
    endtask

    task automatic test_reset_in_wait();
        int t = 0;
        int bs;
        mask8 = 8'h81; resp_en8 = 1'b0; rda8 = 3'd0; en8 = 1'b1;
        while (!wr8 && t < 40) begin tick(1); t++; end
        checks++; if (to8 !== 5'b11111) begin errors++; $display("FAIL rw_cmd got %b exp 11111", to8); end
        tick(3);
        checks++; if (rdv8 !== 1'b1) begin errors++; $display("FAIL rw_pre_valid got %b exp 1", rdv8); end
        rst8_n = 1'b0;
        #2;
        checks++; if ({wr8, to8, len8, rdd8, rdv8} !== 21'd0) begin errors++; $display("FAIL rw_out1 got wr %b cmd %h len %0d rd %h v %b exp 0", wr8, to8, len8, rdd8, rdv8); end
        checks++; if ({sstb8, sch8, sdat8, done8, terr8} !== 16'd0) begin errors++; $display("FAIL rw_out2 got stb %b ch %0d d %h done %b err %b exp 0", sstb8, sch8, sdat8, done8, terr8); end
        @(posedge clk); @(posedge clk); #1;
        rst8_n = 1'b1; resp_en8 = 1'b1;
        t = 0;
        while (!wr8 && t < 40) begin tick(1); t++; end
        checks++; if (to8 !== 5'b11000) begin errors++; $display("FAIL rw_first_cmd got %b exp 11000", to8); end
        bs = n_s8; t = 0;
        while (n_s8 == bs && t < 40) begin tick(1); t++; end
        en8 = 1'b0;
        tick(2);
        rda8 = 3'd7; tick(2);
        checks++; if (rdv8 !== 1'b0) begin errors++; $display("FAIL rw_valid7 got %b exp 0", rdv8); end
        rda8 = 3'd0; tick(2);
        checks++; if ({rdv8, rdd8} !== {1'b1, 10'h155}) begin errors++; $display("FAIL rw_rd0 got v %b d %h exp v 1 d 155", rdv8, rdd8); end
        tick(20);
    endtask

    task automatic test_nch5();
        int t = 0;
        mask5 = 5'h10; en5 = 1'b1;
        while (sch_log5.size() < 3 && t < 200) begin tick(1); t++; end
        en5 = 1'b0;
        tick(30);
        checks++;
        if (sch_log5.size() != 3 || wr_t5.size() != 3) begin errors++; $display("FAIL n5_count got %0d samples %0d frames exp 3", sch_log5.size(), wr_t5.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if ({cmd_log5[i], sch_log5[i], sdat_log5[i], sdone_log5[i]} !== {5'b11100, 3'd4, resp_of(3'd4), 1'b1}) begin errors++; $display("FAIL n5_s%0d got cmd %b ch %0d d %h done %b exp 11100 ch 4 done 1", i, cmd_log5[i], sch_log5[i], sdat_log5[i], sdone_log5[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (wr_t5[i] - wr_t5[i-1] != 17) begin errors++; $display("FAIL n5_period got %0d exp 17", wr_t5[i] - wr_t5[i-1]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_timeout();
        test_enable_drop();
        test_gap_b2b();
        test_reset_in_wait();
        test_nch5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
